// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with iterative 32-step multiply/divide and MTHI/MTLO writes.
// Optional HILO_FAST_MULT_EN: single-step combinational multiply (divide stays iterative).
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            alu_control,
    input  logic                  LO_write_enable,
    input  logic                  HI_write_enable,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_done;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic [W-1:0]   r_raw_a;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_div_op;
    logic           r_div_zero;

    logic           w_accept;
    logic           w_is_mul;
    logic           w_is_div;
    logic           w_signed;
    logic           w_start_mul;
    logic           w_start_div;
    logic           w_mthi;
    logic           w_mtlo;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic           w_last;

    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_trial;
    logic           w_div_ok;
    logic [W-1:0]   w_div_rem;
    logic [2*W-1:0] w_div_next;

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;

    // Request decode: mult/div need both enables since they write HI and LO together.
    assign w_accept    = start && (r_state == S_IDLE);
    assign w_is_mul    = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
    assign w_is_div    = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
    assign w_signed    = (alu_control == OP_MULT) || (alu_control == OP_DIV);
    assign w_start_mul = w_accept && w_is_mul && HI_write_enable && LO_write_enable;
    assign w_start_div = w_accept && w_is_div && HI_write_enable && LO_write_enable;
    assign w_mthi      = w_accept && (alu_control == OP_MTHI) && HI_write_enable;
    assign w_mtlo      = w_accept && (alu_control == OP_MTLO) && LO_write_enable;

    // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
    assign w_abs_a = (w_signed && op_a[W-1]) ? -op_a : op_a;
    assign w_abs_b = (w_signed && op_b[W-1]) ? -op_b : op_b;
    assign w_last  = (r_cnt == LAST_ITER);

    // Shift-add step: upper half accumulates, multiplier bits shift out the bottom.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Restoring step: upper half is the partial remainder, quotient bits enter at the bottom.
    assign w_div_trial = r_acc[2*W-1:W-1] - {1'b0, r_opnd};
    assign w_div_ok    = !w_div_trial[W];
    assign w_div_rem   = w_div_ok ? w_div_trial[W-1:0] : r_acc[2*W-2:W-1];
    assign w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_ok};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

`ifdef HILO_FAST_MULT_EN
    logic [2*W-1:0] w_fast_prod;
    assign w_fast_prod = {{W{1'b0}}, w_abs_a} * {{W{1'b0}}, w_abs_b};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_mul) begin
`ifdef HILO_FAST_MULT_EN
                    w_state_next = S_FIX;
`else
                    w_state_next = S_MUL;
`endif
                end else if (w_start_div) begin
                    w_state_next = S_DIV;
                end
            end
            S_MUL:   if (w_last) w_state_next = S_FIX;
            S_DIV:   if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_raw_a    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_op   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_mul) begin
                        r_opnd   <= w_abs_a;
                        r_neg_q  <= w_signed && (op_a[W-1] ^ op_b[W-1]);
                        r_neg_r  <= 1'b0;
                        r_div_op <= 1'b0;
`ifdef HILO_FAST_MULT_EN
                        r_acc    <= w_fast_prod;
`else
                        r_acc    <= {{W{1'b0}}, w_abs_b};
`endif
                    end else if (w_start_div) begin
                        r_opnd     <= w_abs_b;
                        r_acc      <= {{W{1'b0}}, w_abs_a};
                        r_neg_q    <= w_signed && (op_a[W-1] ^ op_b[W-1]);
                        r_neg_r    <= w_signed && op_a[W-1];
                        r_div_op   <= 1'b1;
                        r_div_zero <= (op_b == '0);
                        r_raw_a    <= op_a;
                    end else if (w_mthi) begin
                        r_hi <= op_a;
                    end else if (w_mtlo) begin
                        r_lo <= op_a;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_div_op) begin
                        r_hi <= w_prod[2*W-1:W];
                        r_lo <= w_prod[W-1:0];
                    end else if (r_div_zero) begin
                        // Divide by zero leaves the raw dividend in HI, all-ones in LO.
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO queued at issue, popped on done.
module tb_hilo_muldiv_unit;

    localparam logic [4:0] C_MULT  = 5'b10000;
    localparam logic [4:0] C_MULTU = 5'b10001;
    localparam logic [4:0] C_DIV   = 5'b10010;
    localparam logic [4:0] C_DIVU  = 5'b10011;
    localparam logic [4:0] C_MTLO  = 5'b10101;
    localparam logic [4:0] C_MTHI  = 5'b10110;

`ifdef HILO_FAST_MULT_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
    localparam logic [4:0] C_LONG_OP = C_DIV;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
    localparam logic [4:0] C_LONG_OP = C_MULT;
`endif
    localparam int DIV_LAT  = 34;
    localparam int DIV_BUSY = 33;
    localparam int TIMEOUT  = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  alu_control;
    logic        LO_write_enable;
    logic        HI_write_enable;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .alu_control     (alu_control),
        .LO_write_enable (LO_write_enable),
        .HI_write_enable (HI_write_enable),
        .op_a            (op_a),
        .op_b            (op_b),
        .busy            (busy),
        .done            (done),
        .hi              (hi),
        .lo              (lo)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        e   = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (code)
            C_MULT: begin
                p = 64'(sa * sbv);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            C_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            C_DIV, C_DIVU: begin
                if (b == 32'h0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else if (code == C_DIV) begin
                    q  = sa / sbv;
                    r  = sa % sbv;
                    qv = 64'(q);
                    rv = 64'(r);
                    e.lo = qv[31:0];
                    e.hi = rv[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic hwe, input logic lwe);
        start           = 1'b1;
        alu_control     = code;
        op_a            = a;
        op_b            = b;
        HI_write_enable = hwe;
        LO_write_enable = lwe;
    endtask

    // Sample k lies between accept edge T(k-1) and Tk; done expected at sample 34.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy === 1'b1) bc++;
        end while (done !== 1'b1 && lat < TIMEOUT);
    endtask

    task automatic do_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   bc;
        int   exp_lat;
        int   exp_busy;
        exp_lat  = (code == C_MULT || code == C_MULTU) ? MUL_LAT : DIV_LAT;
        exp_busy = (code == C_MULT || code == C_MULTU) ? MUL_BUSY : DIV_BUSY;
        @(negedge clk);
        drive(code, a, b, 1'b1, 1'b1);
        scb.push_back(model(code, a, b));
        wait_done(lat, bc);
        e = scb.pop_front();
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL op_latency code=%b: done at sample %0d, required %0d", code, lat, exp_lat);
        end
        n_cmp++;
        if (bc !== exp_busy) begin
            n_bad++;
            $display("FAIL op_busy_cycles code=%b: busy for %0d, required %0d", code, bc, exp_busy);
        end
        n_cmp++;
        if (hi !== e.hi) begin
            n_bad++;
            $display("FAIL op_hi code=%b a=%h b=%h: hi=%h, required %h", code, a, b, hi, e.hi);
        end
        n_cmp++;
        if (lo !== e.lo) begin
            n_bad++;
            $display("FAIL op_lo code=%b a=%h b=%h: lo=%h, required %h", code, a, b, lo, e.lo);
        end
        $display("txn code=%b a=%h b=%h -> hi=%h lo=%h lat=%0d", code, a, b, hi, lo, lat);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        alu_control = 5'b0;
        op_a = 32'h0;
        op_b = 32'h0;
        HI_write_enable = 1'b0;
        LO_write_enable = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: done=%b, required 0", done); end
        n_cmp++;
        if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: hi=%h, required 0", hi); end
        n_cmp++;
        if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: lo=%h, required 0", lo); end
        $display("txn reset -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        reset = 1'b1;
    endtask

    task automatic test_multiply;
        logic [4:0]  codes [6] = '{C_MULTU, C_MULT, C_MULTU, C_MULT, C_MULT, C_MULTU};
        logic [31:0] as    [6] = '{32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs    [6] = '{32'h6, 32'h5, 32'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) do_op(codes[i], as[i], bs[i]);
    endtask

    task automatic test_divide;
        logic [4:0]  codes [7] = '{C_DIV, C_DIVU, C_DIVU, C_DIV, C_DIV, C_DIV, C_DIVU};
        logic [31:0] as    [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h7, 32'hFFFF_FFF9, 32'd100};
        logic [31:0] bs    [7] = '{32'h2, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'd7};
        for (int i = 0; i < 7; i++) do_op(codes[i], as[i], bs[i]);
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        drive(C_MTLO, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_lo: lo=%h, required 12345678", lo); end
        $display("txn MTLO 12345678 -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        drive(C_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (hi !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mthi_hi: hi=%h, required deadbeef", hi); end
        n_cmp++;
        if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_lo_kept: lo=%h, required 12345678", lo); end
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mthi_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
        $display("txn MTHI deadbeef -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        // Codes with their write enable low, or mult/div missing an enable, are no-ops.
        drive(C_MTHI, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(C_MTLO, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(C_MULT, 32'h3, 32'h3, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL noop_busy: busy=%b, required 0", busy); end
        n_cmp++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL noop_hilo: hi=%h lo=%h, required deadbeef 12345678", hi, lo);
        end
        $display("txn disabled writes -> hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int   lat;
        @(negedge clk);
        drive(C_LONG_OP, 32'hFFFF_FFFD, 32'h5, 1'b1, 1'b1);
        scb.push_back(model(C_LONG_OP, 32'hFFFF_FFFD, 32'h5));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat >= 5 && lat < 8) drive(C_MTLO, 32'h55, 32'h0, 1'b0, 1'b1);
            else if (lat >= 8 && lat < 10) drive(C_MTHI, 32'h66, 32'h0, 1'b1, 1'b0);
            else start = 1'b0;
        end while (done !== 1'b1 && lat < TIMEOUT);
        start = 1'b0;
        e = scb.pop_front();
        n_cmp++;
        if (lat !== DIV_LAT) begin n_bad++; $display("FAIL ignore_latency: done at %0d, required %0d", lat, DIV_LAT); end
        n_cmp++;
        if (lo !== e.lo) begin n_bad++; $display("FAIL ignore_lo: lo=%h, required %h", lo, e.lo); end
        n_cmp++;
        if (hi !== e.hi) begin n_bad++; $display("FAIL ignore_hi: hi=%h, required %h", hi, e.hi); end
        $display("txn busy-ignored MTLO/MTHI -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int lat;
        int saw_done;
        @(negedge clk);
        drive(C_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(C_LONG_OP, 32'h1234_5678, 32'h9, 1'b1, 1'b1);
        lat = 0;
        saw_done = 0;
        while (lat < 11) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done === 1'b1) saw_done++;
            if (lat == 10) reset = 1'b0;
        end
        reset = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: busy=%b, required 0", busy); end
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_hilo: hi=%h lo=%h, required 0 0", hi, lo);
        end
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done++;
        end
        n_cmp++;
        if (saw_done !== 0) begin n_bad++; $display("FAIL abort_no_done: activity seen %0d times, required 0", saw_done); end
        $display("txn reset at T10 -> hi=%h lo=%h busy=%b", hi, lo, busy);
        do_op(C_MULTU, 32'h3, 32'h3);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        int   bc;
        @(negedge clk);
        drive(C_DIVU, 32'd1000, 32'd7, 1'b1, 1'b1);
        scb.push_back(model(C_DIVU, 32'd1000, 32'd7));
        wait_done(lat, bc);
        e = scb.pop_front();
        n_cmp++;
        if (hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL b2b_first: hi=%h lo=%h, required %h %h", hi, lo, e.hi, e.lo);
        end
        $display("txn b2b DIVU 1000/7 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        drive(C_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b1);
        scb.push_back(model(C_MULTU, 32'h0001_0000, 32'h0003_0000));
        wait_done(lat, bc);
        e = scb.pop_front();
        n_cmp++;
        if (lat !== MUL_LAT) begin n_bad++; $display("FAIL b2b_latency: done at %0d, required %0d", lat, MUL_LAT); end
        n_cmp++;
        if (hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL b2b_second: hi=%h lo=%h, required %h %h", hi, lo, e.hi, e.lo);
        end
        $display("txn b2b MULTU 10000*30000 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Consumer of the ALU decoder's MULT/MULTU/DIV/DIVU/MTHI/MTLO codes and HI/LO write enables; owns the architectural HI and LO registers.
- Performs iterative 32-cycle multiply and divide, plus single-cycle MTHI/MTLO writes.
- Sits beside the ALU in execute. Drives `busy` so the pipeline stalls on any MFHI/MFLO or new HI/LO op while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on the clk rising edge.
- start  in  1  request valid for one cycle; accepted only when busy=0.
- alu_control  in  5  operation code: MULT=5'b10000, MULTU=5'b10001, DIV=5'b10010, DIVU=5'b10011, MTLO=5'b10101, MTHI=5'b10110.
- LO_write_enable  in  1  from decoder; qualifies a LO update.
- HI_write_enable  in  1  from decoder; qualifies a HI update.
- op_a  in  32  rs value (multiplicand / dividend / MTHI-MTLO source).
- op_b  in  32  rt value (multiplier / divisor).
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mult/div result.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0. Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
- Accept rule: start=1 and state=IDLE at an edge. While busy=1, start is ignored entirely, including MTHI/MTLO; the pipeline must hold the request.
- MTHI: accepted with HI_write_enable=1 -> hi<=op_a at that edge; LO unchanged; state stays IDLE; no done pulse.
- MTLO: accepted with LO_write_enable=1 -> lo<=op_a at that edge; same rules as MTHI.
- Write-enable qualification: a code with its write enable(s) low is a no-op. Any other code is a no-op.
- MULT/MULTU/DIV/DIVU accepted at edge T0:
  - For signed ops, latch |op_a|, |op_b| and the result sign flags. For unsigned ops, latch operands as-is.
  - Clear the iteration counter; go to MUL or DIV.
- MUL: radix-2 shift-add, one bit per cycle, 64-bit accumulator, 32 iterations at edges T1..T32, then FIX.
- DIV: restoring division, one quotient bit per cycle, 32 iterations at edges T1..T32, then FIX.
- FIX at edge T33:
  - Apply sign correction. Product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
  - MUL: hi<=product[63:32], lo<=product[31:0]. DIV: lo<=quotient, hi<=remainder.
  - done=1 for the cycle after T33; state<=IDLE, so busy=0 in that same cycle.
- Latency: accept at T0 -> hi/lo valid and done=1 after edge T33 (33 edges).
- Back-to-back: a new start may be accepted at the edge where done=1 is visible.
- Signed edge cases:
  - |0x80000000| is treated as unsigned 0x80000000.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero (op_b=0), both DIV and DIVU: still 33 edges; lo=0xFFFFFFFF, hi=op_a unchanged (raw dividend, no sign fix).
- hi/lo change only at MTHI/MTLO accept, at FIX, or at reset.

Optional Feature:
- Macro: HILO_FAST_MULT_EN.
- Defined: MULT/MULTU compute the full 64-bit product combinationally at accept. State goes IDLE->FIX, with hi/lo written and done=1 after edge T1 (busy high for one cycle). DIV/DIVU are unchanged.
- Undefined: iterative 33-edge multiply as specified above.

Test Plan:
- MULTU op_a=7, op_b=6 -> busy high for 33 cycles, then done pulse; hi=0x00000000, lo=0x0000002A.
- MULT op_a=0xFFFFFFFD (-3), op_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with MULTU -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op_a=0xFFFFFFFF, op_b=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
- DIVU op_a=0x1234, op_b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 33 edges, with done pulse.
- MTHI 0xDEADBEEF while idle -> hi updates next cycle, lo unchanged, no done. MTLO 0x55 issued while a MULT is busy -> ignored; lo ends with the MULT result.
- Start MULT, assert reset=0 at edge T10 -> busy=0, hi=lo=0, no done pulse. A following MULTU 3*3 completes normally with lo=9.
